tank_ctrl: RTL and testbench

- Parametrised player-tank controller, successor to the fixed debouncer-plus-player datapath in the game top level.
- Runs on the single system clock and uses an internal tick enable instead of a divided clock.
- Synchronises and debounces three raw buttons (left, right, fire), moves the tank horizontally with saturating bounds, and runs a single-projectile fire state machine with hit and cooldown handling.
- Outputs feed the VGA renderer directly.

---
 rtl/tank_pkg.sv | 17 +
 rtl/tank_ctrl_btn_conditioner.sv | 53 +++++
 rtl/tank_ctrl.sv | 135 +++++++++++++
 tb/tb_tank_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared definitions for the player-tank controller: shot FSM states and
// default coordinate constants for the 640x480 screen.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } shot_state_t;

  localparam int DEF_X_W      = 10;
  localparam int DEF_X_MIN    = 0;
  localparam int DEF_X_MAX    = 620;
  localparam int DEF_X_START  = 320;
  localparam int DEF_PLAYER_Y = 440;

endpackage

// File: rtl/tank_ctrl_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, counter debouncer and a one-cycle
// pulse in the same cycle the debounced level first rises.
module btn_conditioner #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic meta;
  logic sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // cnt counts consecutive cycles of disagreement; the flip happens on the
  // DEB_CYCLES-th one and any agreement in between starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync;
          rise  <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tank_ctrl.sv
// Player-tank controller: debounced buttons, tick-paced saturating movement
// and a single-projectile fire FSM with hit and cooldown handling.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int X_W            = DEF_X_W,
  parameter int X_MIN          = DEF_X_MIN,
  parameter int X_MAX          = DEF_X_MAX,
  parameter int X_START        = DEF_X_START,
  parameter int PLAYER_Y       = DEF_PLAYER_Y,
  parameter int STEP           = 4,
  parameter int DEB_CYCLES     = 250000,
  parameter int TICK_DIV       = 2000000,
  parameter int SHOT_OFFSET    = 8,
  parameter int BULLET_STEP    = 8,
  parameter int Y_TOP          = 0,
  parameter int COOLDOWN_TICKS = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_l,
  input  logic           btn_r,
  input  logic           btn_fire,
  input  logic           shot_hit,
  output logic [X_W-1:0] player_x,
  output logic [X_W-1:0] player_y,
  output logic           shot_active,
  output logic [X_W-1:0] shot_x,
  output logic [X_W-1:0] shot_y,
  output logic           tick
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [X_W-1:0] MIN_X     = X_W'(X_MIN);
  localparam logic [X_W-1:0] MAX_X     = X_W'(X_MAX);
  localparam logic [X_W:0]   MIN_E     = (X_W + 1)'(X_MIN);
  localparam logic [X_W:0]   MAX_E     = (X_W + 1)'(X_MAX);
  localparam logic [X_W:0]   STEP_E    = (X_W + 1)'(STEP);
  localparam logic [X_W-1:0] OFF_X     = X_W'(SHOT_OFFSET);
  localparam logic [X_W-1:0] BSTEP     = X_W'(BULLET_STEP);
  localparam logic [X_W-1:0] START_Y   = X_W'(PLAYER_Y);
  localparam logic [X_W:0]   Y_LIM     = (X_W + 1)'(Y_TOP + BULLET_STEP);
  localparam logic [CD_W-1:0] CD_INIT  = CD_W'(COOLDOWN_TICKS);

  logic lvl_l, lvl_r, lvl_fire;
  logic rise_l_unused, rise_r_unused, fire_edge;
  logic [TW-1:0]   tick_cnt;
  logic [X_W:0]    x_ext, x_dec, x_inc;
  shot_state_t     state;
  logic [CD_W-1:0] cd_cnt;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_l (
    .clk(clk), .rst_n(rst_n), .raw(btn_l), .level(lvl_l), .rise(rise_l_unused)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_r (
    .clk(clk), .rst_n(rst_n), .raw(btn_r), .level(lvl_r), .rise(rise_r_unused)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_fire (
    .clk(clk), .rst_n(rst_n), .raw(btn_fire), .level(lvl_fire), .rise(fire_edge)
  );

  assign tick     = (tick_cnt == TICK_LAST);
  assign player_y = START_Y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // One extra bit so the bound tests below can never be fooled by wraparound.
  assign x_ext = {1'b0, player_x};
  assign x_dec = x_ext - STEP_E;
  assign x_inc = x_ext + STEP_E;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_x <= X_W'(X_START);
    end else if (tick) begin
      if (lvl_l && !lvl_r)
        player_x <= (x_ext < MIN_E + STEP_E) ? MIN_X : x_dec[X_W-1:0];
      else if (lvl_r && !lvl_l)
        player_x <= (x_inc > MAX_E) ? MAX_X : x_inc[X_W-1:0];
    end
  end

  // Hit takes priority over a coincident tick, so the shot freezes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shot_active <= 1'b0;
      shot_x      <= '0;
      shot_y      <= '0;
      cd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_edge) begin
            state       <= FLYING;
            shot_active <= 1'b1;
            shot_x      <= player_x + OFF_X;
            shot_y      <= START_Y;
          end
        end
        FLYING: begin
          if (shot_hit) begin
            state       <= COOLDOWN;
            shot_active <= 1'b0;
            cd_cnt      <= CD_INIT;
          end else if (tick) begin
            if ({1'b0, shot_y} < Y_LIM) begin
              state       <= COOLDOWN;
              shot_active <= 1'b0;
              cd_cnt      <= CD_INIT;
            end else begin
              shot_y <= shot_y - BSTEP;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cd_cnt == '0) state <= IDLE;
            else              cd_cnt <= cd_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl with a cycle-level behavioural model and
// hand-computed literal checks.
module tb_tank_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_fire = 1'b0, shot_hit = 1'b0;
  logic [9:0] player_x, player_y, shot_x, shot_y;
  logic shot_active, tick;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  int m_s1[3], m_s2[3], m_lvl[3], m_cnt[3];
  int m_fire_last, m_tcnt, m_x, m_phase, m_active, m_sx, m_sy, m_cd;

  tank_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n), .btn_l(btn_l), .btn_r(btn_r),
    .btn_fire(btn_fire), .shot_hit(shot_hit), .player_x(player_x),
    .player_y(player_y), .shot_active(shot_active), .shot_x(shot_x),
    .shot_y(shot_y), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic f,
                               input logic h, input int n);
    btn_l = l; btn_r = r; btn_fire = f; shot_hit = h;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_cnt[b] = 0;
    end
    m_fire_last = 0; m_tcnt = 0; m_x = 320;
    m_phase = 0; m_active = 0; m_sx = 0; m_sy = 0; m_cd = 0;
  endtask

  // Phase 0 = waiting, 1 = shot in the air, 2 = cooling down.
  task automatic model_step();
    int raw[3];
    bit tk, fe, l, r;
    raw[0] = int'(btn_l); raw[1] = int'(btn_r); raw[2] = int'(btn_fire);
    tk = (m_tcnt == TDIV - 1);
    fe = (m_lvl[2] == 1) && (m_fire_last == 0);
    l  = (m_lvl[0] == 1);
    r  = (m_lvl[1] == 1);
    if (m_phase == 0) begin
      if (fe) begin
        m_phase = 1; m_active = 1; m_sx = m_x + 8; m_sy = 440;
      end
    end else if (m_phase == 1) begin
      if (shot_hit) begin
        m_phase = 2; m_active = 0; m_cd = 2;
      end else if (tk) begin
        if (m_sy < 8) begin
          m_phase = 2; m_active = 0; m_cd = 2;
        end else begin
          m_sy = m_sy - 8;
        end
      end
    end else if (tk) begin
      if (m_cd == 0) m_phase = 0;
      else           m_cd = m_cd - 1;
    end
    if (tk && l && !r) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
    if (tk && r && !l) m_x = (m_x + 4 > 620) ? 620 : m_x + 4;
    m_fire_last = m_lvl[2];
    for (int b = 0; b < 3; b++) begin
      if (m_s2[b] != m_lvl[b]) begin
        m_cnt[b]++;
        if (m_cnt[b] == DEB) begin
          m_lvl[b] = m_s2[b];
          m_cnt[b] = 0;
        end
      end else begin
        m_cnt[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    m_tcnt = tk ? 0 : m_tcnt + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("player_x", int'(player_x), m_x);
      checkOutput("player_y", int'(player_y), 440);
      checkOutput("tick", int'(tick), int'(m_tcnt == TDIV - 1));
      checkOutput("shot_active", int'(shot_active), m_active);
      checkOutput("shot_x", int'(shot_x), m_sx);
      checkOutput("shot_y", int'(shot_y), m_sy);
    end
  end

  initial begin
    int nt;
    bit found;
    model_reset();
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    checkOutput("rst_player_x", int'(player_x), 320);
    checkOutput("rst_player_y", int'(player_y), 440);
    checkOutput("rst_shot_active", int'(shot_active), 0);
    rst_n = 1'b1;

    nt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    checkOutput("tick_count_32", nt, 4);

    btn_fire = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (shot_active) begin found = 1'b1; break; end
    end
    checkOutput("fire_seen", int'(found), 1);
    checkOutput("fire_shot_x", int'(shot_x), 328);
    checkOutput("fire_shot_y", int'(shot_y), 440);
    applyStimulus(0, 0, 0, 0, 12);
    applyStimulus(0, 0, 1, 0, 12);
    applyStimulus(0, 0, 0, 0, 12);

    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (m_phase == 2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("flight_ends", int'(found), 1);
    checkOutput("flight_end_y", int'(shot_y), 0);
    applyStimulus(0, 0, 1, 0, 10);
    applyStimulus(0, 0, 0, 0, 80);
    checkOutput("no_ghost_shot", int'(shot_active), 0);

    applyStimulus(0, 0, 1, 0, 12);
    applyStimulus(0, 0, 0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (m_phase == 1 && m_sy == 200 && m_tcnt == TDIV - 1) begin
        found = 1'b1; break;
      end
      @(negedge clk);
    end
    checkOutput("hit_window", int'(found), 1);
    applyStimulus(0, 0, 0, 1, 1);
    shot_hit = 1'b0;
    checkOutput("hit_active", int'(shot_active), 0);
    checkOutput("hit_y", int'(shot_y), 200);
    applyStimulus(0, 0, 0, 0, 16);
    checkOutput("hit_y_hold", int'(shot_y), 200);
    applyStimulus(0, 0, 0, 0, 40);

    applyStimulus(0, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 30);
    checkOutput("glitch_x", int'(player_x), 320);

    btn_r = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (player_x != 10'd320) break;
    end
    checkOutput("first_step_x", int'(player_x), 324);
    applyStimulus(0, 1, 0, 0, 24);
    applyStimulus(1, 1, 0, 0, 40);
    applyStimulus(0, 0, 0, 0, 12);

    applyStimulus(1, 0, 0, 0, 8 * 110);
    checkOutput("clamp_left", int'(player_x), 0);
    applyStimulus(0, 0, 0, 0, 12);
    checkOutput("clamp_left_hold", int'(player_x), 0);
    applyStimulus(0, 1, 0, 0, 8 * 170);
    checkOutput("clamp_right", int'(player_x), 620);
    applyStimulus(0, 0, 0, 0, 12);

    applyStimulus(0, 0, 1, 0, 12);
    applyStimulus(0, 0, 0, 0, 20);
    checkOutput("fire_at_right_x", int'(shot_x), 628);
    checkOutput("fire_at_right_active", int'(shot_active), 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_active", int'(shot_active), 0);
    checkOutput("rst_mid_x", int'(player_x), 320);
    checkOutput("rst_mid_shot_y", int'(shot_y), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 40);
    checkOutput("no_pending_fire", int'(shot_active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
